pool_sched: RTL and testbench

Round-robin scheduler sharing one 24x20 max-pooling unit among N_CH convolution-channel frame buffers. It grants one requesting channel and streams that channel's 480-word frame into the pool unit as one contiguous write burst. It then collects the 120 pooled results and forwards them tagged with channel and index. It sits between the conv/normalisation channel buffers and the next layer's input buffers.

---
 rtl/pool_sched.sv | 179 +++++++++++++++++
 tb/tb_pool_sched.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_sched.sv
// Round-robin scheduler that shares one max-pooling unit among N_CH frame buffers.
// Each grant streams one frame into the pool unit, then forwards the tagged pooled results.
module pool_sched #(
  parameter int N_CH      = 6,
  parameter int DW        = 12,
  parameter int FRAME_LEN = 480,
  parameter int POOL_LEN  = 120,
  parameter int TIMEOUT   = 1023
) (
  input  logic               cnn_clk,
  input  logic               cnn_rst,
  input  logic [N_CH-1:0]    req,
  output logic [N_CH-1:0]    grant,
  output logic               rd_en,
  input  logic [N_CH*DW-1:0] src_data,
  output logic               pool_wr_en,
  output logic [DW-1:0]      pool_data,
  input  logic               pool_buffer_en,
  input  logic [DW-1:0]      pool_max,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [2:0]         out_ch,
  output logic [6:0]         out_idx,
  output logic               frame_done,
  output logic               busy,
  output logic               timeout_err
);

  localparam logic [8:0] LP_RD_LAST  = 9'(FRAME_LEN - 1);
  localparam logic [6:0] LP_RES_LAST = 7'(POOL_LEN - 1);
  localparam logic [9:0] LP_TO_LAST  = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t            r_state, w_next;
  logic [N_CH-1:0]   r_grant;
  logic [2:0]        r_gnt_idx, r_last;
  logic [8:0]        r_rd_cnt;
  logic              r_rd_en, r_rd_en_d1, r_pool_wr_en;
  logic [DW-1:0]     r_pool_data;
  logic [6:0]        r_res_cnt;
  logic [9:0]        r_to_cnt;
  logic              r_out_valid, r_frame_done, r_timeout_err;
  logic [DW-1:0]     r_out_data;
  logic [2:0]        r_out_ch;
  logic [6:0]        r_out_idx;

  logic              w_found, w_start, w_done, w_abort;
  logic [2:0]        w_win;
  logic [DW-1:0]     w_src;
  int unsigned       w_cand;

  // Search starts one past the last served channel and wraps modulo N_CH.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = 0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      w_cand = {29'd0, r_last} + i;
      if (w_cand >= N_CH) w_cand = w_cand - N_CH;
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (!w_found && k == w_cand && req[k]) begin
          w_found = 1'b1;
          w_win   = 3'(k);
        end
      end
    end
  end

  always_comb begin
    w_src = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (3'(k) == r_gnt_idx) w_src = src_data[k*DW +: DW];
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next  = S_LOAD;
          w_start = 1'b1;
        end
      end
      S_LOAD:  if (r_rd_cnt == LP_RD_LAST) w_next = S_FLUSH;
      S_FLUSH: if (!r_pool_wr_en) w_next = S_DRAIN;
      S_DRAIN: begin
        if (pool_buffer_en) begin
          if (r_res_cnt == LP_RES_LAST) begin
            w_done = 1'b1;
            w_next = S_IDLE;
          end
        end else if (r_to_cnt == LP_TO_LAST) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge cnn_clk or posedge cnn_rst) begin
    if (cnn_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge cnn_clk or posedge cnn_rst) begin
    if (cnn_rst) begin
      r_grant       <= '0;
      r_gnt_idx     <= '0;
      r_last        <= 3'(N_CH - 1);
      r_rd_cnt      <= '0;
      r_rd_en       <= 1'b0;
      r_rd_en_d1    <= 1'b0;
      r_pool_wr_en  <= 1'b0;
      r_pool_data   <= '0;
      r_res_cnt     <= '0;
      r_to_cnt      <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_ch      <= '0;
      r_out_idx     <= '0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rd_en      <= (r_state == S_LOAD);
      r_rd_en_d1   <= r_rd_en;
      r_pool_wr_en <= r_rd_en_d1;
      if (r_rd_en_d1) r_pool_data <= w_src;
      r_out_valid  <= 1'b0;
      r_frame_done <= w_done;
      if (w_start) begin
        r_grant   <= N_CH'(1) << w_win;
        r_gnt_idx <= w_win;
        r_rd_cnt  <= '0;
      end
      if (r_state == S_LOAD) r_rd_cnt <= r_rd_cnt + 9'd1;
      if (r_state == S_FLUSH) begin
        r_res_cnt <= '0;
        r_to_cnt  <= '0;
      end
      // Results arriving outside DRAIN are stale pool-unit activity and are dropped.
      if (r_state == S_DRAIN) begin
        if (pool_buffer_en) begin
          r_out_valid <= 1'b1;
          r_out_data  <= pool_max;
          r_out_ch    <= r_gnt_idx;
          r_out_idx   <= r_res_cnt;
          r_res_cnt   <= r_res_cnt + 7'd1;
          r_to_cnt    <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 10'd1;
        end
      end
      if (w_done || w_abort) begin
        r_grant <= '0;
        r_last  <= r_gnt_idx;
      end
      if (w_abort) r_timeout_err <= 1'b1;
    end
  end

  assign grant       = r_grant;
  assign rd_en       = r_rd_en;
  assign pool_wr_en  = r_pool_wr_en;
  assign pool_data   = r_pool_data;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_ch      = r_out_ch;
  assign out_idx     = r_out_idx;
  assign frame_done  = r_frame_done;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pool_sched.sv
// Scoreboard bench for pool_sched: a round-robin reference model predicts grants, write bursts
// and forwarded results; a pool-unit stub and a source model provide the data.
module tb_pool_sched;
  localparam int N_CH = 6, DW = 12, FRAME_LEN = 480, POOL_LEN = 120, TIMEOUT = 1023;

  logic               cnn_clk, cnn_rst;
  logic [N_CH-1:0]    req, grant;
  logic               rd_en, pool_wr_en, pool_buffer_en;
  logic [N_CH*DW-1:0] src_data;
  logic [DW-1:0]      pool_data, pool_max, out_data;
  logic               out_valid, frame_done, busy, timeout_err;
  logic [2:0]         out_ch;
  logic [6:0]         out_idx;

  pool_sched #(.N_CH(N_CH), .DW(DW), .FRAME_LEN(FRAME_LEN), .POOL_LEN(POOL_LEN),
               .TIMEOUT(TIMEOUT)) dut (
    .cnn_clk(cnn_clk), .cnn_rst(cnn_rst), .req(req), .grant(grant), .rd_en(rd_en),
    .src_data(src_data), .pool_wr_en(pool_wr_en), .pool_data(pool_data),
    .pool_buffer_en(pool_buffer_en), .pool_max(pool_max), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_idx(out_idx), .frame_done(frame_done),
    .busy(busy), .timeout_err(timeout_err));

  initial begin
    cnn_clk = 1'b0;
    forever #5 cnn_clk = ~cnn_clk;
  end

  typedef struct {logic [DW-1:0] d; int ch; int idx; bit done;} res_t;

  int n_cmp = 0, n_err = 0;
  logic [DW-1:0]   exp_wr[$];
  res_t            exp_out[$];
  logic [N_CH-1:0] gnt_log[$];
  int m_last = N_CH - 1, cur_ch = 0, frames = 0, ov_count = 0, idle_cycles = 0;
  int cyc = 0, last_ov_cyc = 0, src_seed = 0, n_results = POOL_LEN, stray_n = 0, wr_cnt = 0;
  bit b2b = 1'b0, to_seen = 1'b0;
  logic [N_CH-1:0] req_at_edge = '0, prev_grant = '0, m_eg;
  logic prev_to = 1'b0;
  int m_e;
  res_t m_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] src_val(int k, int n, int seed);
    int t;
    t = seed + n + 700 * k;
    return t[DW-1:0];
  endfunction

  function automatic int rr_pick(int last, logic [N_CH-1:0] r);
    for (int i = 1; i <= N_CH; i++) begin
      int c;
      c = (last + i) % N_CH;
      for (int k = 0; k < N_CH; k++) if (k == c && r[k]) return c;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge cnn_clk);
    cyc++;
    req_at_edge = req;
  end

  // Source buffers: a read strobe seen in one cycle returns its word in the following cycle.
  initial begin
    int sn;
    bit rd_prev;
    sn = 0;
    rd_prev = 1'b0;
    src_data = '0;
    forever begin
      @(negedge cnn_clk);
      if (rd_prev) begin
        for (int k = 0; k < N_CH; k++) src_data[k*DW +: DW] = src_val(k, sn, src_seed);
        sn++;
      end else if (!rd_en) begin
        sn = 0;
      end
      rd_prev = rd_en;
    end
  end

  // Pool-unit stub: after each complete burst returns n_results values with random gaps.
  initial begin
    int pend, dly, ridx;
    pend = 0; dly = 0; ridx = 0;
    pool_buffer_en = 1'b0;
    pool_max = '0;
    forever begin
      @(negedge cnn_clk);
      pool_buffer_en = 1'b0;
      if (cnn_rst) begin
        wr_cnt = 0;
        pend = 0;
        continue;
      end
      if (pool_wr_en) wr_cnt++;
      else if (wr_cnt != 0) begin
        check("burst_len", wr_cnt, FRAME_LEN);
        if (wr_cnt == FRAME_LEN) begin
          pend = n_results; dly = 6; ridx = 0;
        end
        wr_cnt = 0;
      end
      if (stray_n > 0) begin
        pool_buffer_en = 1'b1;
        pool_max = DW'($urandom);
        stray_n--;
      end else if (pend > 0) begin
        if (dly > 0) dly--;
        else begin
          pool_buffer_en = 1'b1;
          pool_max = DW'($urandom);
          exp_out.push_back('{pool_max, cur_ch, ridx, (ridx == POOL_LEN - 1)});
          ridx++;
          pend--;
          dly = $urandom_range(0, 2);
        end
      end
    end
  end

  // Monitor: grant arbitration, write burst contents, forwarded results, timeout behaviour.
  initial forever begin
    @(negedge cnn_clk);
    if (cnn_rst) begin
      prev_grant = '0;
      prev_to = 1'b0;
      idle_cycles = 0;
      continue;
    end
    if (!busy) idle_cycles++;
    if (grant != '0 && prev_grant == '0) begin
      m_e = rr_pick(m_last, req_at_edge);
      m_eg = '0;
      for (int c = 0; c < N_CH; c++) if (c == m_e) m_eg[c] = 1'b1;
      check("grant", 32'(grant), 32'(m_eg));
      if (b2b) check("idle_gap", idle_cycles, 1);
      b2b = 1'b0;
      idle_cycles = 0;
      cur_ch = m_e;
      gnt_log.push_back(grant);
      for (int n = 0; n < FRAME_LEN; n++) exp_wr.push_back(src_val(m_e, n, src_seed));
    end
    if (pool_wr_en) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 32'(pool_wr_en), 0);
      else check("pool_data", 32'(pool_data), 32'(exp_wr.pop_front()));
    end
    if (frame_done) check("done_with_valid", 32'(out_valid), 1);
    if (out_valid) begin
      ov_count++;
      last_ov_cyc = cyc;
      if (exp_out.size() == 0) check("out_unexpected", 32'(out_valid), 0);
      else begin
        m_r = exp_out.pop_front();
        check("out_data", 32'(out_data), 32'(m_r.d));
        check("out_ch", 32'(out_ch), m_r.ch);
        check("out_idx", 32'(out_idx), m_r.idx);
        check("frame_done", 32'(frame_done), 32'(m_r.done));
        if (m_r.done) begin
          frames++;
          m_last = cur_ch;
          check("grant_clear", 32'(grant), 0);
          b2b = (req_at_edge != '0);
        end
      end
    end
    if (timeout_err && !prev_to) begin
      check("timeout_delay", cyc - last_ov_cyc, TIMEOUT);
      m_last = cur_ch;
      to_seen = 1'b1;
      b2b = 1'b0;
    end
    prev_to = timeout_err;
    prev_grant = grant;
  end

  task automatic check_zero();
    check("rst_grant", 32'(grant), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_pool_wr_en", 32'(pool_wr_en), 0);
    check("rst_pool_data", 32'(pool_data), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
  endtask

  task automatic do_reset();
    @(negedge cnn_clk);
    #2 cnn_rst = 1'b1;
    #1 check_zero();
    exp_wr.delete();
    exp_out.delete();
    m_last = N_CH - 1;
    b2b = 1'b0;
    repeat (2) @(negedge cnn_clk);
    #2 cnn_rst = 1'b0;
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && !busy; i++) @(negedge cnn_clk);
    check("wait_busy", 32'(busy), 1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget && frames < target; i++) @(negedge cnn_clk);
    check("frame_count", frames, target);
  endtask

  task automatic serve(input logic [N_CH-1:0] r);
    int base;
    base = frames;
    src_seed = $urandom_range(0, 4095);
    @(negedge cnn_clk);
    req = r;
    wait_busy(10);
    req = '0;
    wait_frames(base + 1, 1500);
  endtask

  initial begin
    logic [N_CH-1:0] exp_rr[7];
    logic [N_CH-1:0] exp_sw[3];
    int base, lb, base_ov;
    exp_rr = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
    exp_sw = '{6'b001000, 6'b100000, 6'b000010};
    req = '0;
    cnn_rst = 1'b0;
    #1 cnn_rst = 1'b1;
    #1 check_zero();
    repeat (3) @(negedge cnn_clk);
    #2 cnn_rst = 1'b0;

    // Single frame, ch2 source is a plain ramp 0..479
    src_seed = 4096 - 1400;
    base = frames;
    @(negedge cnn_clk);
    req = 6'b000100;
    @(negedge cnn_clk);
    check("t1_grant", 32'(grant), 32'(6'b000100));
    check("t1_busy", 32'(busy), 1);
    req = '0;
    @(negedge cnn_clk);
    check("t1_rd_en", 32'(rd_en), 1);
    wait_frames(base + 1, 1500);

    // Round robin from reset with all requests held
    do_reset();
    src_seed = $urandom_range(0, 4095);
    base = frames;
    lb = gnt_log.size();
    @(negedge cnn_clk);
    req = '1;
    wait_frames(base + 6, 9000);
    wait_busy(10);
    req = '0;
    wait_frames(base + 7, 1500);
    for (int i = 0; i < 7; i++) check("rr_order", 32'(gnt_log[lb + i]), 32'(exp_rr[i]));

    // Skip and wrap after ch3
    lb = gnt_log.size();
    serve(6'b001000);
    base = frames;
    @(negedge cnn_clk);
    req = 6'b100010;
    wait_frames(base + 1, 1500);
    wait_busy(10);
    req = '0;
    wait_frames(base + 2, 1500);
    for (int i = 0; i < 3; i++) check("skip_wrap_order", 32'(gnt_log[lb + i]), 32'(exp_sw[i]));

    // Timeout: only 50 results come back
    n_results = 50;
    to_seen = 1'b0;
    base = frames;
    @(negedge cnn_clk);
    req = 6'b010000;
    wait_busy(10);
    req = '0;
    for (int i = 0; i < 3000 && !to_seen; i++) @(negedge cnn_clk);
    check("timeout_seen", 32'(to_seen), 1);
    check("timeout_err", 32'(timeout_err), 1);
    check("timeout_grant", 32'(grant), 0);
    check("timeout_busy", 32'(busy), 0);
    check("timeout_no_done", frames, base);
    n_results = POOL_LEN;
    serve(6'b000001);
    check("timeout_sticky", 32'(timeout_err), 1);

    // Stray pool results while idle
    base_ov = ov_count;
    stray_n = 3;
    repeat (8) @(negedge cnn_clk);
    check("stray_ignored", ov_count, base_ov);
    serve(6'b000010);

    // Reset in the middle of LOAD, then a clean full frame
    src_seed = $urandom_range(0, 4095);
    @(negedge cnn_clk);
    req = 6'b000001;
    wait_busy(10);
    req = '0;
    for (int i = 0; i < 400 && wr_cnt < 200; i++) @(negedge cnn_clk);
    check("reset_point", 32'(wr_cnt >= 200), 1);
    do_reset();
    serve(6'b000001);

    repeat (20) @(negedge cnn_clk);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("out_queue_empty", exp_out.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule
